mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter that shares the CPU's single byte-wide synchronous RAM port between instruction fetch (IF stage) and load/store (MEM stage). It serialises each 8/16/32-bit access into byte beats, assembles read words little-endian, and returns one-cycle completion pulses to the requesting stage. It also honours the decode-stage jump/flush so that a redirected fetch never returns a stale instruction. It sits between if.v / mem.v and the top-level RAM pins in risc-v.v.

## Interface
- No parameters. Widths come from defs.v: `InstAddrBus`/`RegBus` = 32 bits.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  jump taken in ID; aborts an IF transfer
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse; if_inst valid
- if_inst  out  32  fetched instruction, held until next IF completion
- mem_req  in  1  load/store request; held high until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_width  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data; low bytes used first
- mem_done  out  1  one-cycle pulse; mem_rdata valid
- mem_rdata  out  32  zero-extended load data, held until next load completion
- mem_err  out  1  misalignment flag, valid with mem_done (see Configuration)
- ram_a  out  32  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_wr  out  1  RAM write strobe
- ram_din  in  8  RAM read byte; valid the cycle after ram_a

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration is evaluated each cycle, with cycle 0 being the sampling edge:
  - mem_req=1 → MEM_RD or MEM_WR. MEM has fixed priority because it holds the older instruction.
  - Otherwise if_req=1 and flush=0 → IF_RD.
- Beat count N: IF = 4; MEM = 1/2/4 per mem_width.
- A byte counter k runs 0..N-1, with ram_a = base + k.
  - Address is 32-bit wrap-around, so 0xFFFFFFFF + 1 = 0x00000000.
- Reads:
  - Byte k is captured into data[8k+7:8k] in the cycle after its address is driven.
  - Unused upper bytes are 0.
- Writes:
  - ram_wr=1 for N consecutive cycles.
  - ram_dout = mem_wdata[8k+7:8k].
- On completion the block goes to DONE for one cycle: the matching done pulse is high and requests are ignored. It then returns to IDLE.
- Flush handling:
  - flush=1 in IF_RD → next state IDLE; no if_done; partial data discarded.
  - flush in MEM_* or DONE is ignored; a started store always completes.
- No preemption: a request that arrives mid-transfer waits for IDLE.
- rst mid-transfer: state → IDLE next edge, and the transfer is silently dropped.

## Timing
- Reset values (all outputs): if_done=0, mem_done=0, mem_err=0, ram_wr=0, ram_a=0, ram_dout=0, if_inst=0, mem_rdata=0.
- All outputs are registered.
- Reads of N bytes:
  - ram_a of byte k is driven in cycle k+1.
  - done is high in cycle N+2, so an IF takes 6 cycles.
- Writes of N bytes:
  - ram_wr is high in cycles 1..N.
  - done is high in cycle N+1.
- Back-to-back: the earliest next sampling edge is the cycle after DONE.
- ram_wr is 0 in every non-MEM_WR cycle, and ram_a holds its last value when idle.
- If mem_req and if_req rise together, the MEM transfer completes first. IF is then granted at the next IDLE unless flush is high.

## Configuration
- MEMARB_ALIGN_CHK_EN:
  - Defined: a MEM request with mem_width=1 and addr[0]≠0, or mem_width≥2 and addr[1:0]≠0, does not touch RAM (ram_wr stays 0). It goes IDLE→DONE and asserts mem_done with mem_err=1 in cycle 1. mem_rdata is unchanged.
  - Undefined: mem_err is tied to 0 and misaligned accesses proceed byte-serially like any other access.

## Test plan
- Fetch: RAM[0x100..0x103]=13,05,10,00 with if_req at 0x100 → if_done in cycle 6 with if_inst=0x00100513; ram_wr=0 throughout.
- Store then load: sw 0xDEADBEEF to 0x200, then lh at 0x202 → ram_dout EF,BE,AD,DE in cycles 1..4 and mem_done in cycle 5. The lh returns mem_rdata=0x0000DEAD with mem_done 4 cycles after its grant.
- Conflict: mem_req (lb 0x10) and if_req rise in the same cycle → the MEM read is granted first (mem_done in cycle 3). The IF transfer starts at the next IDLE and if_done appears in cycle 10.
- Flush: assert flush in cycle 3 of an IF read → no if_done pulse, IDLE in cycle 4. A new if_req at 0x40 then fetches correctly.
- Reset mid-store: rst in cycle 2 of sw → ram_wr=0 next cycle, all outputs at reset values, no mem_done. A later request behaves normally.
- MEMARB_ALIGN_CHK_EN: lw at 0x202 → mem_done and mem_err=1 in cycle 1, no RAM access. Without the macro the same request returns bytes 0x202..0x205 with mem_err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM port between instruction fetch and load/store,
// serialising accesses into byte beats. Define MEMARB_ALIGN_CHK_EN to trap misaligned MEM accesses.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  beats;
  logic [31:0] wdata;
  logic [31:0] data;

  function automatic logic [2:0] beat_count(input logic [1:0] width);
    case (width)
      2'd0:    beat_count = 3'd1;
      2'd1:    beat_count = 3'd2;
      default: beat_count = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

`ifdef MEMARB_ALIGN_CHK_EN
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lsb);
    case (width)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lsb[0];
      default: misaligned = |lsb;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      ram_wr    <= 1'b0;
      ram_a     <= 32'd0;
      ram_dout  <= 8'd0;
      if_inst   <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= 3'd0;
          data <= 32'd0;
          // MEM wins over IF: it belongs to the older instruction in the pipe
          if (mem_req) begin
`ifdef MEMARB_ALIGN_CHK_EN
            if (misaligned(mem_width, mem_addr[1:0])) begin
              mem_done <= 1'b1;
              mem_err  <= 1'b1;
              state    <= DONE;
            end else
`endif
            begin
              ram_a   <= mem_addr;
              wdata   <= mem_wdata;
              beats   <= beat_count(mem_width);
              mem_err <= 1'b0;
              if (mem_we) begin
                ram_wr   <= 1'b1;
                ram_dout <= mem_wdata[7:0];
                state    <= MEM_WR;
              end else begin
                state <= MEM_RD;
              end
            end
          end else if (if_req && !flush) begin
            ram_a <= if_addr;
            beats <= 3'd4;
            state <= IF_RD;
          end
        end

        IF_RD, MEM_RD: begin
          if (state == IF_RD && flush) begin
            state <= IDLE;
          end else begin
            // address runs one beat ahead of the byte being captured
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 < beats) ram_a <= ram_a + 32'd1;
            if (cnt != 3'd0) data <= put_byte(data, 2'(cnt - 3'd1), ram_din);
            if (cnt == beats) begin
              state <= DONE;
              if (state == IF_RD) begin
                if_inst <= put_byte(data, 2'(cnt - 3'd1), ram_din);
                if_done <= 1'b1;
              end else begin
                mem_rdata <= put_byte(data, 2'(cnt - 3'd1), ram_din);
                mem_done  <= 1'b1;
                mem_err   <= 1'b0;
              end
            end
          end
        end

        MEM_WR: begin
          if (cnt + 3'd1 < beats) begin
            cnt      <= cnt + 3'd1;
            ram_a    <= ram_a + 32'd1;
            ram_dout <= get_byte(wdata, 2'(cnt + 3'd1));
          end else begin
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
            mem_err  <= 1'b0;
            state    <= DONE;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter against a byte-array RAM and compares with a transaction-level model.
// Expectations follow MEMARB_ALIGN_CHK_EN when the bench is built with it.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush, if_req, mem_req, mem_we, ram_wr, if_done, mem_done, mem_err;
  logic [1:0]  mem_width;
  logic [31:0] if_addr, mem_addr, mem_wdata, if_inst, mem_rdata, ram_a;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  ram       [0:65535];
  logic [7:0]  model_mem [0:65535];
  logic [31:0] last_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always @(posedge clk) begin
    ram_din <= ram[ram_a[15:0]];
    if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
  end

  function automatic int size_of(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit bad_align(input logic [1:0] w, input logic [31:0] a);
`ifdef MEMARB_ALIGN_CHK_EN
    return (int'(a[1:0]) % size_of(w)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_lat(input logic we, input logic [1:0] w, input logic [31:0] a);
    if (bad_align(w, a)) return 1;
    return we ? size_of(w) + 1 : size_of(w) + 2;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] w, input logic [31:0] a);
    logic [31:0] r;
    logic [31:0] p;
    r = 32'd0;
    for (int k = 0; k < size_of(w); k++) begin
      p = a + 32'(k);
      r = r | (32'(model_mem[p[15:0]]) << (8 * k));
    end
    return r;
  endfunction

  task automatic model_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] p;
    for (int k = 0; k < size_of(w); k++) begin
      p = a + 32'(k);
      model_mem[p[15:0]] = 8'(wd >> (8 * k));
    end
  endtask

  // Called at a negedge; returns at the negedge where mem_done is seen (lat = -1 on timeout).
  task automatic run_mem(input logic we, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err, output int wr_n, output int wr_bad);
    lat = -1; rd = 32'd0; err = 1'b0; wr_n = 0; wr_bad = 0;
    mem_req = 1'b1; mem_we = we; mem_width = w; mem_addr = a; mem_wdata = wd;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ram_wr) begin
        if (wr_n >= 4 || ram_a !== a + 32'(wr_n) || ram_dout !== 8'(wd >> (8 * wr_n))) wr_bad++;
        wr_n++;
      end
      if (mem_done) begin
        lat = c; rd = mem_rdata; err = mem_err;
        break;
      end
    end
    mem_req = 1'b0;
  endtask

  task automatic run_if(input logic [31:0] a, output int lat, output logic [31:0] inst,
                        output int wr_n, output int a_bad);
    lat = -1; inst = 32'd0; wr_n = 0; a_bad = 0;
    if_req = 1'b1; if_addr = a;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ram_wr) wr_n++;
      if (c <= 4 && ram_a !== a + 32'(c - 1)) a_bad++;
      if (if_done) begin
        lat = c; inst = if_inst;
        break;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    mem_width = 2'd0; if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({if_done, mem_done, mem_err, ram_wr} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {if_done, mem_done, mem_err, ram_wr});
    end
    n_cmp++; if (ram_a !== 32'd0 || ram_dout !== 8'd0) begin
      n_bad++; $display("FAIL reset_ram: got a=%h dout=%h expected 0", ram_a, ram_dout);
    end
    n_cmp++; if (if_inst !== 32'd0 || mem_rdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_data: got inst=%h rdata=%h expected 0", if_inst, mem_rdata);
    end
    rst = 1'b0;
    last_rdata = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int lat, wr_n, a_bad;
    logic [31:0] inst;
    ram[16'h100] = 8'h13; ram[16'h101] = 8'h05; ram[16'h102] = 8'h10; ram[16'h103] = 8'h00;
    for (int i = 16'h100; i < 16'h104; i++) model_mem[i] = ram[i];
    run_if(32'h100, lat, inst, wr_n, a_bad);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL fetch_lat: got %0d expected 6", lat); end
    n_cmp++; if (inst !== 32'h00100513) begin
      n_bad++; $display("FAIL fetch_inst: got %h expected 00100513", inst);
    end
    n_cmp++; if (wr_n !== 0 || a_bad !== 0) begin
      n_bad++; $display("FAIL fetch_bus: got wr=%0d addr_err=%0d expected 0/0", wr_n, a_bad);
    end
    @(negedge clk);
    n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse: got %b expected 0", if_done); end
  endtask

  task automatic test_store_load();
    int lat, wr_n, wr_bad;
    logic [31:0] rd;
    logic err;
    run_mem(1'b1, 2'd2, 32'h200, 32'hDEADBEEF, lat, rd, err, wr_n, wr_bad);
    model_store(2'd2, 32'h200, 32'hDEADBEEF);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL sw_lat: got %0d expected 5", lat); end
    n_cmp++; if (wr_n !== 4 || wr_bad !== 0) begin
      n_bad++; $display("FAIL sw_beats: got %0d beats %0d bad expected 4/0", wr_n, wr_bad);
    end
    n_cmp++; if (rd !== last_rdata) begin n_bad++; $display("FAIL sw_rdata_held: got %h expected %h", rd, last_rdata); end
    @(negedge clk);
    n_cmp++; if (mem_done !== 1'b0 || ram_wr !== 1'b0) begin
      n_bad++; $display("FAIL sw_after: got done=%b wr=%b expected 0/0", mem_done, ram_wr);
    end
    run_mem(1'b0, 2'd1, 32'h202, 32'd0, lat, rd, err, wr_n, wr_bad);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL lh_lat: got %0d expected 4", lat); end
    n_cmp++; if (rd !== 32'h0000DEAD) begin n_bad++; $display("FAIL lh_data: got %h expected 0000dead", rd); end
    last_rdata = 32'h0000DEAD;
    @(negedge clk);
  endtask

  task automatic test_conflict();
    int md, id;
    logic [31:0] rd, inst, exp_i, exp_b;
    md = -1; id = -1; rd = 32'd0; inst = 32'd0;
    exp_b = model_load(2'd0, 32'h10);
    exp_i = model_load(2'd2, 32'h100);
    mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h10;
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (mem_done && md < 0) begin md = c; rd = mem_rdata; mem_req = 1'b0; end
      if (if_done && id < 0) begin id = c; inst = if_inst; if_req = 1'b0; break; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    n_cmp++; if (md !== 3) begin n_bad++; $display("FAIL conflict_mem_lat: got %0d expected 3", md); end
    n_cmp++; if (id !== 10) begin n_bad++; $display("FAIL conflict_if_lat: got %0d expected 10", id); end
    n_cmp++; if (rd !== exp_b) begin n_bad++; $display("FAIL conflict_rdata: got %h expected %h", rd, exp_b); end
    n_cmp++; if (inst !== exp_i) begin n_bad++; $display("FAIL conflict_inst: got %h expected %h", inst, exp_i); end
    last_rdata = exp_b;
    @(negedge clk);
  endtask

  task automatic test_flush();
    int seen, lat, wr_n, a_bad;
    logic [31:0] inst;
    seen = 0;
    if_req = 1'b1; if_addr = 32'h80;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (if_done) seen++;
      if (c == 3) begin flush = 1'b1; if_req = 1'b0; end
      if (c == 4) flush = 1'b0;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end
    run_if(32'h40, lat, inst, wr_n, a_bad);
    n_cmp++; if (lat !== 6 || a_bad !== 0) begin
      n_bad++; $display("FAIL flush_refetch_lat: got %0d addr_err=%0d expected 6/0", lat, a_bad);
    end
    n_cmp++; if (inst !== model_load(2'd2, 32'h40)) begin
      n_bad++; $display("FAIL flush_refetch_inst: got %h expected %h", inst, model_load(2'd2, 32'h40));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    int seen, lat, wr_n, wr_bad;
    logic [31:0] rd;
    logic err;
    seen = 0;
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'h300; mem_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({if_done, mem_done, mem_err, ram_wr, ram_a, ram_dout, if_inst, mem_rdata} !== '0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got wr=%b done=%b a=%h dout=%h rdata=%h expected all 0",
                        ram_wr, mem_done, ram_a, ram_dout, mem_rdata);
    end
    rst = 1'b0;
    // beats 0 and 1 reached the RAM before reset was sampled
    model_store(2'd1, 32'h300, 32'h00003344);
    last_rdata = 32'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_done || ram_wr) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", seen); end
    run_mem(1'b0, 2'd2, 32'h300, 32'd0, lat, rd, err, wr_n, wr_bad);
    n_cmp++; if (lat !== 6 || rd !== model_load(2'd2, 32'h300)) begin
      n_bad++; $display("FAIL rst_mid_reload: got lat=%0d data=%h expected 6/%h", lat, rd, model_load(2'd2, 32'h300));
    end
    last_rdata = model_load(2'd2, 32'h300);
    @(negedge clk);
  endtask

  task automatic test_align();
    int lat, wr_n, wr_bad;
    logic [31:0] rd, a_before, exp_rd;
    logic err;
    a_before = ram_a;
    exp_rd = bad_align(2'd2, 32'h202) ? last_rdata : model_load(2'd2, 32'h202);
    run_mem(1'b0, 2'd2, 32'h202, 32'd0, lat, rd, err, wr_n, wr_bad);
    n_cmp++; if (lat !== exp_lat(1'b0, 2'd2, 32'h202)) begin
      n_bad++; $display("FAIL align_lw_lat: got %0d expected %0d", lat, exp_lat(1'b0, 2'd2, 32'h202));
    end
    n_cmp++; if (err !== bad_align(2'd2, 32'h202)) begin
      n_bad++; $display("FAIL align_lw_err: got %b expected %b", err, bad_align(2'd2, 32'h202));
    end
    n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL align_lw_data: got %h expected %h", rd, exp_rd); end
    if (bad_align(2'd2, 32'h202)) begin
      n_cmp++; if (ram_a !== a_before) begin
        n_bad++; $display("FAIL align_lw_addr: got %h expected %h", ram_a, a_before);
      end
    end
    last_rdata = exp_rd;
    @(negedge clk);
    run_mem(1'b1, 2'd1, 32'h401, 32'h0000A55A, lat, rd, err, wr_n, wr_bad);
    if (!bad_align(2'd1, 32'h401)) model_store(2'd1, 32'h401, 32'h0000A55A);
    n_cmp++; if (wr_n !== (bad_align(2'd1, 32'h401) ? 0 : 2) || wr_bad !== 0 || err !== bad_align(2'd1, 32'h401)) begin
      n_bad++; $display("FAIL align_sh: got beats=%0d bad=%0d err=%b", wr_n, wr_bad, err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, wr_n, wr_bad;
    logic [31:0] rd, wd;
    logic err;
    wd = $urandom;
    run_mem(1'b1, 2'd2, 32'h500, wd, lat, rd, err, wr_n, wr_bad);
    model_store(2'd2, 32'h500, wd);
    run_mem(1'b0, 2'd2, 32'h500, 32'd0, lat, rd, err, wr_n, wr_bad);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL b2b_lat: got %0d expected 7", lat); end
    n_cmp++; if (rd !== wd) begin n_bad++; $display("FAIL b2b_data: got %h expected %h", rd, wd); end
    last_rdata = wd;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, wr_n, wr_bad, gap, elat, diffs, a_bad;
    logic [31:0] rd, a, wd, exp_rd;
    logic [1:0] w;
    logic we, err;
    for (int i = 0; i < 60; i++) begin
      gap = (i == 0) ? 1 : int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        run_if(a, lat, rd, wr_n, a_bad);
        elat = 6 + ((gap == 0) ? 1 : 0);
        n_cmp++; if (lat !== elat || wr_n !== 0 || rd !== model_load(2'd2, a)) begin
          n_bad++; $display("FAIL rand_if[%0d]: got lat=%0d inst=%h expected %0d/%h", i, lat, rd, elat, model_load(2'd2, a));
        end
      end else begin
        we = 1'($urandom); w = 2'($urandom); wd = $urandom;
        exp_rd = (we || bad_align(w, a)) ? last_rdata : model_load(w, a);
        run_mem(we, w, a, wd, lat, rd, err, wr_n, wr_bad);
        if (we && !bad_align(w, a)) model_store(w, a, wd);
        elat = exp_lat(we, w, a) + ((gap == 0) ? 1 : 0);
        n_cmp++; if (lat !== elat || rd !== exp_rd || err !== bad_align(w, a)) begin
          n_bad++; $display("FAIL rand_mem[%0d]: got lat=%0d data=%h err=%b expected %0d/%h/%b",
                            i, lat, rd, err, elat, exp_rd, bad_align(w, a));
        end
        n_cmp++; if (wr_n !== ((we && !bad_align(w, a)) ? size_of(w) : 0) || wr_bad !== 0) begin
          n_bad++; $display("FAIL rand_wr[%0d]: got beats=%0d bad=%0d", i, wr_n, wr_bad);
        end
        last_rdata = exp_rd;
      end
    end
    @(negedge clk);
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== model_mem[i]) diffs++;
    n_cmp++; if (diffs !== 0) begin n_bad++; $display("FAIL ram_contents: got %0d differing bytes expected 0", diffs); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'($urandom);
      model_mem[i] = ram[i];
    end
    test_reset();
    test_fetch();
    test_store_load();
    test_conflict();
    test_flush();
    test_reset_mid_store();
    test_align();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
